// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide engine that owns the HI/LO
// registers. Operands are reduced to magnitudes at start. One shift-add
// (multiply) or restoring-subtract (divide) step is done per cycle. Signs are
// applied in a final FIX cycle. Latency is fixed at WIDTH+1 cycles.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [4:0] OP_MULT  = 5'b10001;
  localparam logic [4:0] OP_MULTU = 5'b10010;
  localparam logic [4:0] OP_DIV   = 5'b10011;
  localparam logic [4:0] OP_DIVU  = 5'b10100;

  logic [1:0]         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;     // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd_reg;    // mult: |multiplicand|; div: |divisor|
  logic [WIDTH-1:0]   araw_reg;    // raw dividend, returned in HI on divide-by-zero
  logic               is_div_reg;
  logic               neg_q_reg;   // product / quotient must be negated
  logic               neg_r_reg;   // remainder must be negated (dividend sign)
  logic               bzero_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               divzero_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  // Operand decode and magnitude extraction at the start boundary
  logic             op_valid;
  logic             op_signed;
  logic             op_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Decode the op code and form operand magnitudes and result signs
  always_comb begin
    op_valid  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    a_neg     = op_signed && a[WIDTH-1];
    b_neg     = op_signed && b[WIDTH-1];
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
  end

  // Per-cycle datapath step candidates and FIX-cycle sign-corrected results
  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_part;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // One radix-2 step of each algorithm, plus sign fix-up of the final accumulator
  always_comb begin
    // Shift-add: add multiplicand into the upper half when the multiplier LSB is set
    mul_add  = acc_reg[0] ? opnd_reg : '0;
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    mul_next = {mul_sum, acc_reg[WIDTH-1:1]};
    // Restoring divide: shift in next dividend bit, trial-subtract the divisor
    div_part = acc_reg[2*WIDTH-1:WIDTH-1];
    div_diff = div_part - {1'b0, opnd_reg};
    div_ok   = ~div_diff[WIDTH];
    div_next = {(div_ok ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0]),
                acc_reg[WIDTH-2:0], div_ok};
    // Sign correction
    acc_hi   = acc_reg[2*WIDTH-1:WIDTH];
    acc_lo   = acc_reg[WIDTH-1:0];
    prod_fix = neg_q_reg ? (~acc_reg + 1'b1) : acc_reg;
    quo_fix  = neg_q_reg ? (~acc_lo + 1'b1) : acc_lo;
    rem_fix  = neg_r_reg ? (~acc_hi + 1'b1) : acc_hi;
  end

  // Control FSM and iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      araw_reg   <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      bzero_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (flush) begin
        state_reg <= S_IDLE;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start && op_valid) begin
              is_div_reg <= op_div;
              neg_q_reg  <= a_neg ^ b_neg;
              neg_r_reg  <= a_neg;
              bzero_reg  <= op_div && (b == '0);
              araw_reg   <= a;
              opnd_reg   <= op_div ? b_mag : a_mag;
              acc_reg    <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
              cnt_reg    <= CNT_W'(WIDTH - 1);
              busy_reg   <= 1'b1;
              state_reg  <= S_CALC;
            end
          end
          S_CALC: begin
            acc_reg <= is_div_reg ? div_next : mul_next;
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == '0) begin
              state_reg <= S_FIX;
            end
          end
          S_FIX: begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
          default: begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  // HI/LO/divzero: result write on completion, mthi/mtlo only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg      <= '0;
      lo_reg      <= '0;
      divzero_reg <= 1'b0;
    end else if (state_reg == S_FIX && !flush) begin
      if (is_div_reg && bzero_reg) begin
        hi_reg      <= araw_reg;
        lo_reg      <= '1;
        divzero_reg <= 1'b1;
      end else if (is_div_reg) begin
        hi_reg      <= rem_fix;
        lo_reg      <= quo_fix;
        divzero_reg <= 1'b0;
      end else begin
        hi_reg      <= prod_fix[2*WIDTH-1:WIDTH];
        lo_reg      <= prod_fix[WIDTH-1:0];
        divzero_reg <= 1'b0;
      end
    end else if (!busy_reg) begin
      if (hi_we) hi_reg <= wdata;
      if (lo_we) lo_reg <= wdata;
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign divzero = divzero_reg;
  assign hi      = hi_reg;
  assign lo      = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven and randomized checks of muldiv_unit against a
// 64-bit arithmetic reference model, plus flush/reset/mthi sequences.
module tb_muldiv_unit;

  localparam logic [4:0] OP_MULT  = 5'b10001;
  localparam logic [4:0] OP_MULTU = 5'b10010;
  localparam logic [4:0] OP_DIV   = 5'b10011;
  localparam logic [4:0] OP_DIVU  = 5'b10100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  op = 5'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic        divzero;
  logic [31:0] hi;
  logic [31:0] lo;

  int passed = 0;
  int total  = 0;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural definitions
  task automatic model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint      sx, sy, sp, sq, sr;
    logic [63:0] up, res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    edz = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      OP_MULT: begin
        sp = sx * sy; res = sp; eh = res[63:32]; el = res[31:0];
      end
      OP_MULTU: begin
        up = {32'b0, x} * {32'b0, y}; eh = up[63:32]; el = up[31:0];
      end
      OP_DIV: begin
        if (y == 0) begin
          el = 32'hFFFF_FFFF; eh = x; edz = 1'b1;
        end else begin
          sq = sx / sy; sr = sx % sy;
          res = sq; el = res[31:0];
          res = sr; eh = res[31:0];
        end
      end
      default: begin
        if (y == 0) begin
          el = 32'hFFFF_FFFF; eh = x; edz = 1'b1;
        end else begin
          el = x / y; eh = x % y;
        end
      end
    endcase
  endtask

  // Called at #1 after a rising edge; returns at #1 after the start edge
  task automatic do_start(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 5'b0; a = $urandom; b = $urandom;
  endtask

  // Counts edges until done is seen (bounded); lat=-1 on timeout
  task automatic wait_done(output int lat);
    bit seen;
    seen = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (!seen) begin
        @(posedge clk); #1;
        if (done) begin
          lat = k; seen = 1'b1;
        end
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz);
    int lat;
    do_start(o, x, y);
    chk({tag, "_busy_after_start"}, busy, 1);
    wait_done(lat);
    chk({tag, "_latency"}, lat, 33);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    chk({tag, "_divzero"}, divzero, edz);
    $display("op=%b a=%h b=%h -> hi=%h lo=%h dz=%b lat=%0d", o, x, y, hi, lo, divzero, lat);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    logic [31:0] pre_hi, pre_lo, eh, el, x, y;
    logic        edz;
    logic [4:0]  ro;
    int          ndone, lat;

    vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    vecs[4] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{OP_MULTU, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0};
    vecs[6] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[7] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[9] = '{OP_MULT,  32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 32'h0000_0000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_divzero", divzero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dz);
    end

    // Invalid op with start is ignored
    start = 1'b1; op = 5'b00101; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    chk("badop_busy", busy, 0);

    // Flush mid-CALC, with an ignored start while busy
    pre_hi = hi; pre_lo = lo;
    do_start(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; op = OP_MULTU; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("flush_busy_ignored_start", busy, 1);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_drop", busy, 0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("flush_no_done", ndone, 0);
    chk("flush_hi_kept", hi, pre_hi);
    chk("flush_lo_kept", lo, pre_lo);
    run_op("after_flush", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    // Flush in the FIX cycle wins over completion
    pre_hi = hi; pre_lo = lo;
    do_start(OP_MULTU, 32'd5, 32'd6);
    repeat (32) @(posedge clk);
    #1;
    chk("fixflush_busy", busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fixflush_done", done, 0);
    chk("fixflush_busy_drop", busy, 0);
    chk("fixflush_hi", hi, pre_hi);
    chk("fixflush_lo", lo, pre_lo);

    // Asynchronous reset mid-CALC
    do_start(OP_MULT, 32'd3, 32'd4);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // mthi ignored while busy, honoured while idle
    do_start(OP_MULTU, 32'd7, 32'd9);
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi_busy_ignored", hi, 0);
    wait_done(lat);
    chk("mthi_op_latency", lat + 1, 33);
    chk("mthi_op_lo", lo, 63);
    @(posedge clk); #1;
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi_idle_hi", hi, 32'hA5A5_A5A5);
    chk("mthi_idle_lo", lo, 63);

    // mtlo coincident with an accepted start: write, then result overwrites
    lo_we = 1'b1; wdata = 32'h1234_5678;
    do_start(OP_MULTU, 32'd2, 32'd3);
    lo_we = 1'b0;
    chk("mtlo_start_lo", lo, 32'h1234_5678);
    chk("mtlo_start_busy", busy, 1);
    wait_done(lat);
    chk("mtlo_op_latency", lat, 33);
    chk("mtlo_op_lo", lo, 6);
    chk("mtlo_op_hi", hi, 0);
    @(posedge clk); #1;

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: ro = OP_MULT;
        1: ro = OP_MULTU;
        2: ro = OP_DIV;
        default: ro = OP_DIVU;
      endcase
      x = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = $urandom_range(1, 15);
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3: y = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: y = $urandom;
      endcase
      model(ro, x, y, eh, el, edz);
      run_op($sformatf("rnd%0d", i), ro, x, y, eh, el, edz);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
